// File: rtl/buzzer_sequencer.sv
// Shares one alarm buzzer between keypad beep, door chime and intrusion alarm.
// Fixed-priority arbitration, tick-timed patterns and a silent gap after every sound.
module buzzer_sequencer #(
  parameter int TICK_DIV     = 50000,
  parameter int BEEP_MS      = 50,
  parameter int CHIME_ON_MS  = 200,
  parameter int CHIME_OFF_MS = 100,
  parameter int CHIME_REPS   = 2,
  parameter int ALARM_MS     = 30000,
  parameter int GAP_MS       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_beep,
  input  logic       door_chime,
  input  logic       alarm_trig,
  input  logic       silence,
  output logic       buzz_on,
  output logic [1:0] pattern,
  output logic       busy,
  output logic       alarm_active,
  output logic [7:0] drop_cnt
);

  localparam int M0 = (BEEP_MS > CHIME_ON_MS) ? BEEP_MS : CHIME_ON_MS;
  localparam int M1 = (M0 > CHIME_OFF_MS) ? M0 : CHIME_OFF_MS;
  localparam int M2 = (M1 > ALARM_MS) ? M1 : ALARM_MS;
  localparam int MAX_MS = (M2 > GAP_MS) ? M2 : GAP_MS;
  localparam int TW = $clog2(MAX_MS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(CHIME_REPS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BEEP, S_CHIME_ON, S_CHIME_OFF, S_ALARM, S_HOLDOFF
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   timer, load_val;
  logic [RW-1:0]   rep, rep_nx;
  logic            pending, pend_nx;
  logic            load, tick, expire;
  logic [1:0]      drops;
  logic [8:0]      drop_sum;
  logic            buzz_nx;
  logic [1:0]      pat_nx;

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign expire = tick && (timer == TW'(1)) && (state != S_IDLE);

  // Requests are single-cycle pulses with no back-pressure: each one is
  // accepted, folded into pending_chime, or counted in drop_cnt that cycle.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    rep_nx   = rep;
    pend_nx  = pending;
    drops    = 2'd0;

    if (expire) begin
      case (state)
        S_BEEP, S_ALARM: begin
          state_nx = S_HOLDOFF; load = 1'b1; load_val = TW'(GAP_MS);
        end
        S_CHIME_ON: begin
          load = 1'b1;
          if (rep < RW'(CHIME_REPS)) begin
            state_nx = S_CHIME_OFF; load_val = TW'(CHIME_OFF_MS);
          end else begin
            state_nx = S_HOLDOFF; load_val = TW'(GAP_MS);
          end
        end
        S_CHIME_OFF: begin
          state_nx = S_CHIME_ON; load = 1'b1; load_val = TW'(CHIME_ON_MS);
          rep_nx   = rep + RW'(1);
        end
        default: ;
      endcase
    end

    if (silence && state != S_IDLE) begin
      // Abort discards the old pending chime; a chime in the same cycle
      // lands in HOLDOFF as a fresh pending request.
      state_nx = S_HOLDOFF; load = 1'b1; load_val = TW'(GAP_MS);
      pend_nx  = door_chime;
      if (key_beep) drops = drops + 2'd1;
    end else if (alarm_trig) begin
      state_nx = S_ALARM; load = 1'b1; load_val = TW'(ALARM_MS);
      pend_nx  = 1'b0;
      if (door_chime) drops = drops + 2'd1;
      if (key_beep)   drops = drops + 2'd1;
    end else begin
      if (door_chime) begin
        if (state == S_IDLE || state == S_BEEP) begin
          state_nx = S_CHIME_ON; load = 1'b1; load_val = TW'(CHIME_ON_MS);
          rep_nx   = RW'(1);
        end else if (state == S_ALARM || pending) begin
          drops = drops + 2'd1;
        end else begin
          pend_nx = 1'b1;
        end
      end
      if (key_beep) begin
        if (state == S_IDLE && !door_chime) begin
          state_nx = S_BEEP; load = 1'b1; load_val = TW'(BEEP_MS);
        end else begin
          drops = drops + 2'd1;
        end
      end
      if (state == S_HOLDOFF && expire) begin
        if (pend_nx) begin
          state_nx = S_CHIME_ON; load = 1'b1; load_val = TW'(CHIME_ON_MS);
          rep_nx   = RW'(1);
          pend_nx  = 1'b0;
        end else begin
          state_nx = S_IDLE;
        end
      end
    end
  end

  always_comb begin
    buzz_nx = 1'b0;
    pat_nx  = 2'b00;
    case (state_nx)
      S_BEEP:      begin buzz_nx = 1'b1; pat_nx = 2'b01; end
      S_CHIME_ON:  begin buzz_nx = 1'b1; pat_nx = 2'b10; end
      S_CHIME_OFF: begin buzz_nx = 1'b0; pat_nx = 2'b10; end
      S_ALARM:     begin buzz_nx = 1'b1; pat_nx = 2'b11; end
      default: ;
    endcase
  end

  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drops};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      presc        <= '0;
      timer        <= '0;
      rep          <= '0;
      pending      <= 1'b0;
      buzz_on      <= 1'b0;
      pattern      <= 2'b00;
      busy         <= 1'b0;
      alarm_active <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      state   <= state_nx;
      rep     <= rep_nx;
      pending <= pend_nx;
      if (load) begin
        presc <= '0;
        timer <= load_val;
      end else if (state_nx == S_IDLE) begin
        presc <= '0;
        timer <= '0;
      end else if (tick) begin
        presc <= '0;
        timer <= timer - TW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      buzz_on      <= buzz_nx;
      pattern      <= pat_nx;
      busy         <= (state_nx != S_IDLE);
      alarm_active <= (state_nx == S_ALARM);
      drop_cnt     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: segment table of {request, length, expected outputs}
// plus hand-written saturation and reset-during-alarm sequences.
module tb_buzzer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_beep, door_chime, alarm_trig, silence;
  logic       buzz_on;
  logic [1:0] pattern;
  logic       busy, alarm_active;
  logic [7:0] drop_cnt;

  buzzer_sequencer #(
    .TICK_DIV(4), .BEEP_MS(3), .CHIME_ON_MS(2), .CHIME_OFF_MS(1),
    .CHIME_REPS(2), .ALARM_MS(10), .GAP_MS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .key_beep(key_beep), .door_chime(door_chime),
    .alarm_trig(alarm_trig), .silence(silence),
    .buzz_on(buzz_on), .pattern(pattern), .busy(busy),
    .alarm_active(alarm_active), .drop_cnt(drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  localparam logic [3:0] RN = 4'b0000;
  localparam logic [3:0] RB = 4'b0001;
  localparam logic [3:0] RC = 4'b0010;
  localparam logic [3:0] RA = 4'b0100;
  localparam logic [3:0] RS = 4'b1000;

  typedef struct {
    logic [3:0] req;
    int         len;
    logic       buzz;
    logic [1:0] pat;
    logic       busy;
    logic       alarm;
    logic [7:0] drop;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(logic [3:0] r, int n, logic bz, logic [1:0] p,
                              logic by, logic al, logic [7:0] d);
    vec_t v;
    v.req = r; v.len = n; v.buzz = bz; v.pat = p; v.busy = by; v.alarm = al; v.drop = d;
    return v;
  endfunction

  function automatic logic [12:0] pack(logic bz, logic [1:0] p, logic by,
                                       logic al, logic [7:0] d);
    return {bz, p, by, al, d};
  endfunction

  // driver + scoreboard: expected pushed with the stimulus, popped after the edge
  task automatic run_cycle(input logic [3:0] r, input logic [12:0] e, input string name);
    logic [12:0] got, want;
    {silence, alarm_trig, door_chime, key_beep} = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    {silence, alarm_trig, door_chime, key_beep} = RN;
    got  = {buzz_on, pattern, busy, alarm_active, drop_cnt};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got buzz=%b pat=%b busy=%b alarm=%b drop=%0d, want buzz=%b pat=%b busy=%b alarm=%b drop=%0d",
               name, got[12], got[11:10], got[9], got[8], got[7:0],
               want[12], want[11:10], want[9], want[8], want[7:0]);
    end
  endtask

  task automatic add_chime_seq(input logic [3:0] r0, input logic [7:0] d0, input logic [7:0] d);
    vecs.push_back(mk(r0, 8, 1, 2'b10, 1, 0, d0));
    vecs.push_back(mk(RN, 4, 0, 2'b10, 1, 0, d));
    vecs.push_back(mk(RN, 8, 1, 2'b10, 1, 0, d));
    vecs.push_back(mk(RN, 8, 0, 2'b00, 1, 0, d));
  endtask

  initial begin
    rst = 1'b1;
    {silence, alarm_trig, door_chime, key_beep} = RN;

    // beep
    vecs.push_back(mk(RB, 12, 1, 2'b01, 1, 0, 0));
    vecs.push_back(mk(RN, 8,  0, 2'b00, 1, 0, 0));
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 0));
    // chime: 8 on, 4 off, 8 on, 8 holdoff
    add_chime_seq(RC, 0, 0);
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 0));
    // chime preempts beep; beep during chime is dropped
    vecs.push_back(mk(RB, 5,  1, 2'b01, 1, 0, 0));
    vecs.push_back(mk(RC, 8,  1, 2'b10, 1, 0, 0));
    vecs.push_back(mk(RN, 4,  0, 2'b10, 1, 0, 0));
    vecs.push_back(mk(RB, 8,  1, 2'b10, 1, 0, 1));
    vecs.push_back(mk(RN, 8,  0, 2'b00, 1, 0, 1));
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 1));
    // alarm with retrigger at cycle 30 -> ends at 70
    vecs.push_back(mk(RA, 30, 1, 2'b11, 1, 1, 1));
    vecs.push_back(mk(RA, 40, 1, 2'b11, 1, 1, 1));
    vecs.push_back(mk(RN, 8,  0, 2'b00, 1, 0, 1));
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 1));
    // silence aborts alarm
    vecs.push_back(mk(RA, 5,  1, 2'b11, 1, 1, 1));
    vecs.push_back(mk(RS, 8,  0, 2'b00, 1, 0, 1));
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 1));
    // chime during beep holdoff starts right after the gap
    vecs.push_back(mk(RB, 12, 1, 2'b01, 1, 0, 1));
    vecs.push_back(mk(RN, 1,  0, 2'b00, 1, 0, 1));
    vecs.push_back(mk(RC, 7,  0, 2'b00, 1, 0, 1));
    add_chime_seq(RN, 1, 1);
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 1));
    // two chimes during CHIME_ON: one pending, one dropped
    vecs.push_back(mk(RC, 1,  1, 2'b10, 1, 0, 1));
    vecs.push_back(mk(RC, 1,  1, 2'b10, 1, 0, 1));
    vecs.push_back(mk(RC, 6,  1, 2'b10, 1, 0, 2));
    vecs.push_back(mk(RN, 4,  0, 2'b10, 1, 0, 2));
    vecs.push_back(mk(RN, 8,  1, 2'b10, 1, 0, 2));
    vecs.push_back(mk(RN, 8,  0, 2'b00, 1, 0, 2));
    add_chime_seq(RN, 2, 2);
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 2));
    // chime+beep together in IDLE: chime wins, beep dropped
    add_chime_seq(RC | RB, 3, 3);
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 3));
    // alarm preempts chime; chime in alarm dropped
    vecs.push_back(mk(RC, 3,  1, 2'b10, 1, 0, 3));
    vecs.push_back(mk(RA, 4,  1, 2'b11, 1, 1, 3));
    vecs.push_back(mk(RC, 1,  1, 2'b11, 1, 1, 4));
    vecs.push_back(mk(RS, 8,  0, 2'b00, 1, 0, 4));
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 4));
    // beep on the BEEP expiry edge is judged against BEEP and dropped
    vecs.push_back(mk(RB, 12, 1, 2'b01, 1, 0, 4));
    vecs.push_back(mk(RB, 8,  0, 2'b00, 1, 0, 5));
    vecs.push_back(mk(RN, 2,  0, 2'b00, 0, 0, 5));
    // silence in IDLE is ignored
    vecs.push_back(mk(RS, 2,  0, 2'b00, 0, 0, 5));

    // reset state
    run_cycle(RN, pack(0, 2'b00, 0, 0, 0), "reset0");
    run_cycle(RN, pack(0, 2'b00, 0, 0, 0), "reset1");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].len; c++) begin
        run_cycle((c == 0) ? vecs[i].req : RN,
                  pack(vecs[i].buzz, vecs[i].pat, vecs[i].busy, vecs[i].alarm, vecs[i].drop),
                  $sformatf("vec%0d_c%0d", i, c));
      end
    end

    // saturation: 300 beeps while alarm is kept alive
    for (int i = 0; i < 300; i++) begin
      int d;
      d = (6 + i > 255) ? 255 : 6 + i;
      run_cycle(RB | (((i % 20) == 0) ? RA : RN), pack(1, 2'b11, 1, 1, d[7:0]),
                $sformatf("sat%0d", i));
    end

    // reset mid-alarm silences on the next edge
    rst = 1'b1;
    run_cycle(RN, pack(0, 2'b00, 0, 0, 0), "rst_in_alarm");
    rst = 1'b0;
    run_cycle(RN, pack(0, 2'b00, 0, 0, 0), "idle_after_rst");
    run_cycle(RB, pack(1, 2'b01, 1, 0, 0), "beep_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
- Owns the alarm buzzer and shares it between three requesters: keypad beep, door chime and intrusion alarm.
- Arbitrates by fixed priority, times each sound pattern with a millisecond tick, and enforces a silent gap between sounds.
- Drives the buzzer's enable input (`buzz_on` feeds `aux`; high = sound) and reports status to the control center.

Parameters:
- TICK_DIV, 50000, clk cycles per tick (1 ms at 50 MHz)
- BEEP_MS, 50, beep length in ticks
- CHIME_ON_MS, 200, chime tone length in ticks
- CHIME_OFF_MS, 100, gap between chime tones in ticks
- CHIME_REPS, 2, number of chime tones (>=1)
- ALARM_MS, 30000, alarm auto-timeout in ticks
- GAP_MS, 20, silent holdoff after any sound, in ticks

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_beep  in  1  one-cycle beep request
- door_chime  in  1  one-cycle chime request
- alarm_trig  in  1  one-cycle alarm request/retrigger
- silence  in  1  one-cycle abort of any sound
- buzz_on  out  1  buzzer enable (to buzzer `aux`)
- pattern  out  2  00 off, 01 beep, 10 chime, 11 alarm
- busy  out  1  high whenever state != IDLE
- alarm_active  out  1  high in ALARM
- drop_cnt  out  8  saturating count of dropped requests

Behaviour:
- States: IDLE, BEEP, CHIME_ON, CHIME_OFF, ALARM, HOLDOFF.
- All outputs are registered. Outputs are decoded from next-state, so they change on the same edge as the state.
- Request-to-output latency is one edge: a request sampled at edge k changes the outputs after edge k.
- Reset: state IDLE; prescaler, timer, rep count and pending_chime = 0; all outputs 0. Reset mid-sound silences on the next edge.
- Timing:
  - The prescaler clears on every state entry, so a state of N ticks lasts exactly N*TICK_DIV cycles.
  - Timer loads N on entry and decrements on each tick. The state exits on the tick that takes it to 0.
- Priority: silence > alarm_trig > door_chime > key_beep. Evaluated in every state, every cycle.
- silence, from any non-IDLE state: go to HOLDOFF and clear pending_chime. In IDLE, silence is ignored.
- alarm_trig:
  - From any state: enter ALARM (buzz_on=1, pattern=11) with timer=ALARM_MS and clear pending_chime.
  - A retrigger in ALARM reloads the timer.
  - On timeout: go to HOLDOFF.
- door_chime:
  - In IDLE or BEEP: preempts and enters CHIME_ON with rep=1.
  - In CHIME_ON/CHIME_OFF or HOLDOFF: sets pending_chime. If pending_chime is already set, the request is dropped.
  - In ALARM: dropped.
- Chime sequence:
  - CHIME_ON (buzz_on=1, pattern=10) for CHIME_ON_MS.
  - If rep < CHIME_REPS: go to CHIME_OFF (buzz_on=0, pattern=10) for CHIME_OFF_MS, then rep+1 and back to CHIME_ON.
  - After the last CHIME_ON: go to HOLDOFF.
- key_beep:
  - Accepted only in IDLE: BEEP (buzz_on=1, pattern=01) for BEEP_MS, then HOLDOFF.
  - In any other state it is dropped.
- HOLDOFF: buzz_on=0, pattern=00, busy=1 for GAP_MS. On exit: if pending_chime, clear it and enter CHIME_ON with rep=1; else go to IDLE.
- Simultaneous events:
  - Highest priority wins. Each lower-priority request in the same cycle is handled per the rules of the winning destination state.
  - Example: chime+beep in IDLE gives CHIME_ON, and the beep is dropped.
- drop_cnt increments by the number of requests dropped that cycle (0..2) and saturates at 255.
- A request arriving on the same edge as a timer expiry is evaluated against the current state, not the next.

Test Plan:
All scenarios use TICK_DIV=4, BEEP_MS=3, CHIME_ON_MS=2, CHIME_OFF_MS=1, CHIME_REPS=2, ALARM_MS=10, GAP_MS=2.
- Beep: key_beep in IDLE at edge k -> buzz_on=1, pattern=01 for exactly 12 cycles; then 8 cycles with busy=1, buzz_on=0; then IDLE with busy=0, drop_cnt=0.
- Chime: door_chime in IDLE -> buzz_on high 8 cycles, low 4, high 8; then HOLDOFF 8 cycles; pattern=10 throughout both tones and the gap between them.
- Preemption: key_beep, then door_chime 5 cycles later -> CHIME_ON on the next edge. A second key_beep during the chime -> drop_cnt=1.
- Alarm and silence: alarm_trig -> alarm_active=1, pattern=11. Retrigger at cycle 30 -> alarm lasts until cycle 30+40. silence at any point -> HOLDOFF on the next edge, alarm_active=0.
- Pending chime: door_chime during BEEP's HOLDOFF -> CHIME_ON immediately after the 8-cycle gap. Two chimes during CHIME_ON -> one pending, drop_cnt=1.
- Reset and saturation: assert rst during ALARM -> all outputs 0 next edge. 300 key_beeps issued while in ALARM -> drop_cnt=255.
